// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: instruction-fetch / program-counter stage.
// Holds the PC and fetches one word per instruction over a ready handshake.
// Latches the returned instruction and presents its opcode to the decoder.
// Computes the following PC from jump/branch controls once the instruction executes.
`timescale 1ns/1ps

module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   input  logic        branch,
   input  logic        zero,
   input  logic        j_c,
   input  logic        stall,
   output logic [31:0] instr,
   output logic [5:0]  op_c,
   output logic        instr_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2
   } state_e;

   // The PC is always word aligned, so the low bits of the reset value are dropped.
   localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

   state_e      state_q;
   logic [31:0] pc_q;
   logic [31:0] instr_q;
   logic        valid_q;
   logic        req_q;
   logic [31:0] next_pc_d;
   logic [31:0] branch_off_d;
   logic [31:0] pc_plus4_d;

   assign pc_plus4_d  = pc_q + 32'd4;
   assign pc_plus4    = pc_plus4_d;
   assign pc          = pc_q;
   assign imem_addr   = pc_q;
   assign imem_req    = req_q;
   assign instr       = instr_q;
   assign op_c        = instr_q[31:26];
   assign instr_valid = valid_q;

   // Next-PC selection: jump beats a taken branch, otherwise fall through to pc+4.
   always_comb begin
      branch_off_d = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
      next_pc_d    = pc_plus4_d;
      if (j_c) begin
         next_pc_d = {pc_plus4_d[31:28], instr_q[25:0], 2'b00};
      end else if (branch && zero) begin
         next_pc_d = pc_plus4_d + branch_off_d;
      end
   end

   // Fetch/execute sequencer with registered request, instruction, valid and PC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC_ALIGNED;
         instr_q <= 32'h0000_0000;
         valid_q <= 1'b0;
         req_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               state_q <= FETCH;
               req_q   <= 1'b1;
            end
            FETCH: begin
               if (imem_ready) begin
                  instr_q <= imem_rdata;
                  valid_q <= 1'b1;
                  req_q   <= 1'b0;
                  state_q <= EXEC;
               end
            end
            EXEC: begin
               if (!stall) begin
                  pc_q    <= next_pc_d;
                  valid_q <= 1'b0;
                  req_q   <= 1'b1;
                  state_q <= FETCH;
               end
            end
            default: begin
               state_q <= IDLE;
               req_q   <= 1'b0;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
Instruction-fetch and program-counter stage that sits directly upstream of the main decoder. It holds the PC and issues word fetches to instruction memory over a ready handshake. It latches the returned instruction and presents op_c (instr[31:26]) to the decoder. It computes the next PC from the decoder's branch/j_c outputs and the ALU zero flag.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] are forced to 2'b00 internally.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
imem_req  output  1  fetch request to instruction memory.
imem_addr  output  32  word-aligned fetch address; equals pc while imem_req=1.
imem_rdata  input  32  instruction returned by memory.
imem_ready  input  1  memory response valid; sampled only while imem_req=1.
branch  input  1  decoder branch control (BEQ).
zero  input  1  ALU zero flag for the current instruction.
j_c  input  1  decoder jump control.
stall  input  1  hold the current instruction; no PC update.
instr  output  32  latched current instruction.
op_c  output  6  instr[31:26], feeds the decoder.
instr_valid  output  1  instr holds a completed fetch; datapath may commit.
pc  output  32  address of the current instruction.
pc_plus4  output  32  pc + 4, combinational.

Behaviour:
- Reset (rst_n=0, asynchronous, effective immediately, including mid-fetch):
  - state=IDLE, pc=RESET_PC & ~3, instr=0, instr_valid=0, imem_req=0.
  - A pending memory response is discarded.
- FSM states: IDLE, FETCH, EXEC.
  - IDLE: one cycle after rst_n deasserts, go to FETCH.
  - FETCH: imem_req=1, imem_addr=pc.
    - imem_ready=0: stay in FETCH, holding imem_req and imem_addr.
    - imem_ready=1: instr<=imem_rdata, instr_valid<=1, go to EXEC.
  - EXEC: imem_req=0, instr_valid=1.
    - stall=1: stay in EXEC; pc and instr hold.
    - stall=0: pc<=next_pc, instr_valid<=0, go to FETCH.
- Minimum instruction period: 2 cycles (zero-wait memory). Each wait cycle adds one.
- next_pc, evaluated in EXEC:
  - j_c=1: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - else branch=1 and zero=1: pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00}).
  - else: pc_plus4.
  - j_c has priority over branch when both are asserted.
- Arithmetic:
  - All arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 with no flag.
  - Negative branch offsets wrap likewise.
  - pc[1:0] is always 2'b00.
- Boundary cases:
  - imem_ready outside FETCH is ignored.
  - branch, zero and j_c outside EXEC are ignored.
  - stall in FETCH is ignored; the fetch completes and the stall takes effect in EXEC.
  - op_c is driven from instr at all times. Consumers must qualify it with instr_valid; after reset op_c=0 with instr_valid=0.
- Outputs are registered except imem_addr, op_c and pc_plus4, which are combinational from registers only (no input-to-output combinational path).

Test Plan:
1. Reset then zero-wait memory returning 32'h0000_0020 (RTYPE) at each address -> fetch addresses 0x0, 0x4, 0x8 on successive 2-cycle periods; op_c=0 with instr_valid=1 in each EXEC.
2. Memory inserts 3 wait cycles at address 0x4 -> imem_req and imem_addr=0x4 held for 4 cycles; instr updates only on the ready cycle; pc unchanged meanwhile.
3. At pc=0x10, instr=32'h1000_FFFE (BEQ offset -2), branch=1, zero=1 -> next fetch at 0x0C. Same with zero=0 -> next fetch at 0x14.
4. At pc=0x4000_0000, instr=32'h0800_0100, j_c=1 and branch=1 simultaneously -> next fetch at 0x4000_0400 (jump wins).
5. stall=1 for 5 EXEC cycles at pc=0x8 -> pc, instr and instr_valid held; no imem_req. stall drop -> fetch at 0xC.
6. RESET_PC=32'hFFFF_FFFE -> first fetch at 0xFFFF_FFFC, then 0x0 (wrap). rst_n pulsed low mid-FETCH -> imem_req drops immediately; restart at 0xFFFF_FFFC.
